// File: rtl/morse_symbol_ctrl.sv
// morse_symbol_ctrl: mark/space timing, dot/dash classification, letter assembly.
// Define MORSE_WORD_GAP_EN to include the GAP state and word_gap output.
module morse_symbol_ctrl #(
  parameter int unsigned CNT_BITS   = 8,
  parameter int unsigned DOT_MAX    = 2,
  parameter int unsigned LETTER_GAP = 3,
  parameter int unsigned WORD_GAP   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       key,
  output logic       sym_valid,
  output logic       sym_dash,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_err,
  output logic       word_gap
);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_e;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] DOT_LIM = CNT_BITS'(DOT_MAX);
  localparam logic [CNT_BITS-1:0] LG_CNT  = CNT_BITS'(LETTER_GAP);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [CNT_BITS-1:0] WG_CNT  = CNT_BITS'(WORD_GAP);
`endif

  if (!(DOT_MAX < LETTER_GAP && LETTER_GAP < WORD_GAP &&
        WORD_GAP <= (2**CNT_BITS) - 1)) begin : g_cfg_err
    $error("morse_symbol_ctrl: inconsistent timing parameters");
  end

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic                key_prev_q;
  logic                rise;
  logic                dash;
  logic [4:0]          code_q, code_d;
  logic [2:0]          len_q, len_d;
  logic                ovf_q, ovf_d;

  logic       sym_valid_q, sym_valid_d;
  logic       sym_dash_q, sym_dash_d;
  logic       letter_valid_q, letter_valid_d;
  logic [4:0] letter_code_q, letter_code_d;
  logic [2:0] letter_len_q, letter_len_d;
  logic       letter_err_q, letter_err_d;
  logic       word_gap_q, word_gap_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      key_prev_q     <= 1'b1;
      code_q         <= '0;
      len_q          <= '0;
      ovf_q          <= 1'b0;
      sym_valid_q    <= 1'b0;
      sym_dash_q     <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_code_q  <= '0;
      letter_len_q   <= '0;
      letter_err_q   <= 1'b0;
      word_gap_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      key_prev_q     <= key;
      code_q         <= code_d;
      len_q          <= len_d;
      ovf_q          <= ovf_d;
      sym_valid_q    <= sym_valid_d;
      sym_dash_q     <= sym_dash_d;
      letter_valid_q <= letter_valid_d;
      letter_code_q  <= letter_code_d;
      letter_len_q   <= letter_len_d;
      letter_err_q   <= letter_err_d;
      word_gap_q     <= word_gap_d;
    end
  end

  // A tick on a key-edge cycle belongs to the interval that is ending.
  assign cnt_inc = (tick && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  assign rise    = key & ~key_prev_q;
  assign dash    = cnt_inc > DOT_LIM;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_inc;
    code_d         = code_q;
    len_d          = len_q;
    ovf_d          = ovf_q;
    sym_valid_d    = 1'b0;
    sym_dash_d     = sym_dash_q;
    letter_valid_d = 1'b0;
    letter_code_d  = letter_code_q;
    letter_len_d   = letter_len_q;
    letter_err_d   = letter_err_q;
    word_gap_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MARK;
          cnt_d   = '0;
          code_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      MARK: begin
        if (!key) begin
          cnt_d = '0;
          if (cnt_inc == '0) begin
            state_d = (len_q != '0) ? SPACE : IDLE;
          end else begin
            state_d     = SPACE;
            sym_valid_d = 1'b1;
            sym_dash_d  = dash;
            if (len_q < 3'd5) begin
              code_d = {code_q[3:0], dash};
              len_d  = len_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      SPACE: begin
        if (cnt_inc >= LG_CNT) begin
          letter_valid_d = 1'b1;
          letter_code_d  = code_q;
          letter_len_d   = len_q;
          letter_err_d   = ovf_q;
          if (rise) begin
            state_d = MARK;
            cnt_d   = '0;
            code_d  = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
          end else begin
`ifdef MORSE_WORD_GAP_EN
            state_d = GAP;
`else
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end
        end else if (rise) begin
          state_d = MARK;
          cnt_d   = '0;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      GAP: begin
        if (cnt_inc >= WG_CNT) begin
          word_gap_d = 1'b1;
        end
        if (rise) begin
          state_d = MARK;
          cnt_d   = '0;
          code_d  = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end else if (cnt_inc >= WG_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sym_valid    = sym_valid_q;
  assign sym_dash     = sym_dash_q;
  assign letter_valid = letter_valid_q;
  assign letter_code  = letter_code_q;
  assign letter_len   = letter_len_q;
  assign letter_err   = letter_err_q;
  assign word_gap     = word_gap_q;

endmodule
